elevator_dispatcher: RTL and testbench
======================================

ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 SHALL have parameter N_FLOORS, default 11, number of served floors (2..16).
REQ-002 SHALL have parameter N_LIFTS, default 4, number of lift cars (1..8).
REQ-003 SHALL have parameter MAX_PEND, default 3, max hall calls outstanding per lift.
REQ-004 SHALL derive FW = clog2(N_FLOORS) floor-index width and CW = clog2(MAX_PEND+1) count width.
REQ-005 SHALL use one clock; reset is synchronous and active-high, with ports:
  clk  in  1  system clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  hall_up_req  in  N_FLOORS  one-cycle up-call pulses, bit f = floor f
  hall_dn_req  in  N_FLOORS  one-cycle down-call pulses
  lift_floor  in  N_LIFTS*FW  current floor per lift, lift k at [k*FW +: FW]
  lift_dir  in  N_LIFTS*2  per lift 00 idle, 01 up, 10 down (11 treated as idle)
  lift_arrive  in  N_LIFTS  one-cycle pulse: lift k doors open at lift_floor[k]
  assign_valid  out  N_LIFTS  one-hot assignment offer
  assign_floor  out  N_LIFTS*FW  offered floor per lift
  assign_up  out  N_LIFTS  offered call direction, 1 = up
  assign_ready  in  N_LIFTS  lift accepts offer
  hall_up_lamp  out  N_FLOORS  up call pending (unassigned or assigned)
  hall_dn_lamp  out  N_FLOORS  down call pending
  busy  out  1  high when FSM not IDLE

Function
REQ-006 SHALL latch hall_up_req[f]/hall_dn_req[f] into pending slots at the sampling edge; request on an already-pending slot is ignored.
REQ-007 SHALL hold 2*N_FLOORS slots (up slots 0..N-1, down N..2N-1), each with pending, assigned and owner-lift fields; lamps equal pending bits.
REQ-008 SHALL run FSM IDLE -> SCORE -> ISSUE -> IDLE; one call dispatched at a time.
REQ-009 IDLE: select first slot pending & ~assigned, searching round-robin from pointer rr; capture slot, go SCORE; stay IDLE if none.
REQ-010 SCORE: lift k eligible if count[k] < MAX_PEND and (dir idle, or dir up & up call & lift_floor <= f, or dir down & down call & lift_floor >= f).
REQ-011 SCORE: cost = |lift_floor[k] - f| computed at FW+1 bits unsigned; choose minimum-cost eligible lift, ties to lowest index; capture, go ISSUE.
REQ-012 SCORE with no eligible lift: return IDLE, rr = slot+1 modulo 2*N_FLOORS, call stays pending unassigned.
REQ-013 ISSUE: assert assign_valid[k] only, assign_floor[k]=f, assign_up[k]=direction; hold stable until assign_ready[k].
REQ-014 Handshake (valid & ready same cycle): mark slot assigned, owner=k, count[k]+1, drop valid next cycle, rr = slot+1, go IDLE.
REQ-015 Latency: request sampled at edge N -> assign_valid high from edge N+2 when FSM was IDLE and a lift eligible.
REQ-016 lift_arrive[k] at floor g: clear every assigned slot at g owned by k (up and/or down), count[k] minus number cleared.
REQ-017 Arrival clear and new request to same slot same cycle: slot ends pending, unassigned (set wins).
REQ-018 Arrival for lift k during its own ISSUE: clear and count update apply; offer still held.
REQ-019 Offered slot cannot be cleared while in ISSUE (it is unassigned); count never exceeds MAX_PEND nor underflows.
REQ-020 Unused assign_floor/assign_up lanes SHALL be zero.

Reset
REQ-021 rst SHALL clear all pending/assigned/owner fields, counts, rr, to IDLE; assign_valid, assign_floor, assign_up, lamps, busy all 0 at next edge.
REQ-022 rst during ISSUE SHALL drop assign_valid next cycle, no count change.

Structure
REQ-023 Package elevator_pkg SHALL hold lift_dir encoding constants, FSM state enum, and FW/CW width functions.
REQ-024 Sub-module dispatch_cost SHALL be combinational: floors, dirs, counts, call floor/dir in -> chosen lift index and found flag out.

Verification
REQ-025 Idle lifts at floors 0,5,8,10; hall_up_req[6] -> assign_valid=0010, assign_floor[1]=6, lamp up[6]=1 at edge N+2.
REQ-026 Lift 0 floor 3 dir up, lift 1 floor 7 dir up; hall_dn_req[5] with lifts 2,3 at count 3 -> no offer, lamp stays, rr advances.
REQ-027 Lifts 0,1 both idle at floor 4, up call floor 4 -> lift 0 chosen (tie); lift 0 then lift_arrive at 4 -> lamp cleared, count[0]=0.
REQ-028 Up and down calls at floor 2 both assigned to lift 2; lift_arrive[2] at floor 2 -> both lamps off, count[2] 2 -> 0.
REQ-029 assign_ready held 0 for 20 cycles -> valid/floor stable; rst asserted -> valid 0, lamps 0 next edge.
REQ-030 Arrival clear plus hall_up_req same floor same cycle -> lamp stays 1, slot re-dispatched.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator hall-call dispatcher:
// lift direction codes, dispatcher FSM states and width helpers.
package elevator_pkg;

    localparam logic [1:0] DIR_IDLE     = 2'b00;
    localparam logic [1:0] DIR_UP       = 2'b01;
    localparam logic [1:0] DIR_DN       = 2'b10;
    localparam logic [1:0] DIR_IDLE_ALT = 2'b11;  // reserved code, behaves as idle

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCORE = 2'd1,
        ST_ISSUE = 2'd2
    } disp_state_e;

    // Floor-index width
    function automatic int fw_of(input int n_floors);
        return (n_floors > 1) ? $clog2(n_floors) : 1;
    endfunction

    // Per-lift outstanding-call counter width
    function automatic int cw_of(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

    // Index width for a set of n items, never below one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dispatch_cost.sv
// Combinational lift selection: picks the eligible lift closest to the
// call floor, lowest index winning ties.
module dispatch_cost
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 11,
    parameter int N_LIFTS  = 4,
    parameter int MAX_PEND = 3,
    localparam int FW = fw_of(N_FLOORS),
    localparam int CW = cw_of(MAX_PEND),
    localparam int LW = idx_w(N_LIFTS)
) (
    input  logic [N_LIFTS*FW-1:0] lift_floor,
    input  logic [N_LIFTS*2-1:0]  lift_dir,
    input  logic [N_LIFTS*CW-1:0] counts,
    input  logic [FW-1:0]         call_floor,
    input  logic                  call_up,
    output logic [LW-1:0]         lift_idx,
    output logic                  found
);

    // Scan all lifts and keep the cheapest eligible one
    always_comb begin
        logic [FW-1:0] fl;
        logic [FW:0]   cost;
        logic [FW:0]   best_cost;
        logic          elig;
        logic          take;
        found     = 1'b0;
        lift_idx  = '0;
        best_cost = '0;
        fl        = '0;
        cost      = '0;
        elig      = 1'b0;
        take      = 1'b0;
        for (int k = 0; k < N_LIFTS; k++) begin
            fl = lift_floor[k*FW +: FW];
            case (lift_dir[k*2 +: 2])
                DIR_IDLE, DIR_IDLE_ALT: elig = 1'b1;
                DIR_UP:                 elig = call_up && (fl <= call_floor);
                DIR_DN:                 elig = !call_up && (fl >= call_floor);
                default:                elig = 1'b0;
            endcase
            elig = elig && (counts[k*CW +: CW] < CW'(MAX_PEND));
            cost = (fl >= call_floor) ? ({1'b0, fl} - {1'b0, call_floor})
                                      : ({1'b0, call_floor} - {1'b0, fl});
            take      = elig && (!found || (cost < best_cost));
            best_cost = take ? cost : best_cost;
            lift_idx  = take ? LW'(k) : lift_idx;
            found     = found || take;
        end
    end

endmodule

// File: rtl/elevator_dispatcher.sv
// Hall-call dispatcher: latches up/down hall calls into slots, offers one
// unassigned call at a time to the best lift, and retires calls on arrival.
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 11,
    parameter int N_LIFTS  = 4,
    parameter int MAX_PEND = 3,
    localparam int FW = fw_of(N_FLOORS),
    localparam int CW = cw_of(MAX_PEND)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_FLOORS-1:0]   hall_up_req,
    input  logic [N_FLOORS-1:0]   hall_dn_req,
    input  logic [N_LIFTS*FW-1:0] lift_floor,
    input  logic [N_LIFTS*2-1:0]  lift_dir,
    input  logic [N_LIFTS-1:0]    lift_arrive,
    output logic [N_LIFTS-1:0]    assign_valid,
    output logic [N_LIFTS*FW-1:0] assign_floor,
    output logic [N_LIFTS-1:0]    assign_up,
    input  logic [N_LIFTS-1:0]    assign_ready,
    output logic [N_FLOORS-1:0]   hall_up_lamp,
    output logic [N_FLOORS-1:0]   hall_dn_lamp,
    output logic                  busy
);

    localparam int LW = idx_w(N_LIFTS);
    localparam int NS = 2 * N_FLOORS;   // up slots first, then down slots
    localparam int SW = idx_w(NS);

    disp_state_e           state, next_state;
    logic [NS-1:0]         pending, assigned, pending_n, assigned_n;
    logic [NS-1:0]         req_vec, clr_vec;
    logic [LW-1:0]         owner   [NS];
    logic [LW-1:0]         owner_n [NS];
    logic [CW-1:0]         count   [N_LIFTS];
    logic [CW-1:0]         count_n [N_LIFTS];
    logic [N_LIFTS*CW-1:0] count_flat;
    logic [SW-1:0]         rr, cur_slot, sel_slot, slot_inc;
    logic [LW-1:0]         cur_lift, cost_lift, issue_lift;
    logic                  sel_found, cost_found, hs, call_up;
    logic [FW-1:0]         call_floor;
    logic [N_LIFTS-1:0]    valid_n, up_n, valid_r, up_r;
    logic [N_LIFTS*FW-1:0] floor_n, floor_r;
    logic                  busy_r;

    assign req_vec    = {hall_dn_req, hall_up_req};
    assign call_up    = (cur_slot < SW'(N_FLOORS));
    assign call_floor = call_up ? FW'(cur_slot) : FW'(cur_slot - SW'(N_FLOORS));
    assign slot_inc   = (cur_slot == SW'(NS - 1)) ? '0 : (cur_slot + SW'(1));
    assign hs         = (state == ST_ISSUE) && assign_ready[cur_lift];
    assign issue_lift = (state == ST_SCORE) ? cost_lift : cur_lift;

    assign assign_valid = valid_r;
    assign assign_floor = floor_r;
    assign assign_up    = up_r;
    assign hall_up_lamp = pending[N_FLOORS-1:0];
    assign hall_dn_lamp = pending[NS-1:N_FLOORS];
    assign busy         = busy_r;

    // Flatten per-lift counts for the cost block
    always_comb begin
        count_flat = '0;
        for (int k = 0; k < N_LIFTS; k++) begin
            count_flat[k*CW +: CW] = count[k];
        end
    end

    dispatch_cost #(
        .N_FLOORS (N_FLOORS),
        .N_LIFTS  (N_LIFTS),
        .MAX_PEND (MAX_PEND)
    ) u_cost (
        .lift_floor (lift_floor),
        .lift_dir   (lift_dir),
        .counts     (count_flat),
        .call_floor (call_floor),
        .call_up    (call_up),
        .lift_idx   (cost_lift),
        .found      (cost_found)
    );

    // Round-robin search for the next pending, unassigned slot starting at rr
    always_comb begin
        int   idx;
        logic hit;
        sel_found = 1'b0;
        sel_slot  = '0;
        idx       = 0;
        hit       = 1'b0;
        for (int i = 0; i < NS; i++) begin
            idx       = int'(rr) + i;
            idx       = (idx >= NS) ? (idx - NS) : idx;
            hit       = !sel_found && pending[idx] && !assigned[idx];
            sel_slot  = hit ? SW'(idx) : sel_slot;
            sel_found = sel_found || hit;
        end
    end

    // Slot next-state: arrival clears, new calls set (set wins), handshake assigns
    always_comb begin
        logic [LW-1:0] own;
        logic          clr;
        logic          take;
        int            g;
        pending_n  = pending;
        assigned_n = assigned;
        clr_vec    = '0;
        own        = '0;
        clr        = 1'b0;
        take       = 1'b0;
        g          = 0;
        for (int s = 0; s < NS; s++) begin
            g    = (s < N_FLOORS) ? s : (s - N_FLOORS);
            own  = owner[s];
            clr  = assigned[s] && lift_arrive[own]
                   && (lift_floor[int'(own)*FW +: FW] == FW'(g));
            take = hs && (cur_slot == SW'(s));
            clr_vec[s]    = clr;
            pending_n[s]  = clr ? req_vec[s] : (pending[s] || req_vec[s]);
            assigned_n[s] = clr ? 1'b0 : (assigned[s] || take);
            owner_n[s]    = take ? cur_lift : owner[s];
        end
    end

    // Per-lift count: +1 on accepted offer, -1 per slot cleared by its arrival
    always_comb begin
        int c;
        c = 32'sd0;
        for (int k = 0; k < N_LIFTS; k++) begin
            c = int'(count[k]) + ((hs && (cur_lift == LW'(k))) ? 32'sd1 : 32'sd0);
            for (int s = 0; s < NS; s++) begin
                c = c - ((clr_vec[s] && (owner[s] == LW'(k))) ? 32'sd1 : 32'sd0);
            end
            count_n[k] = (c < 32'sd0) ? '0
                       : ((c > MAX_PEND) ? CW'(MAX_PEND) : CW'(c));
        end
    end

    // Slot and count storage
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            assigned <= '0;
            for (int s = 0; s < NS; s++) owner[s] <= '0;
            for (int k = 0; k < N_LIFTS; k++) count[k] <= '0;
        end else begin
            pending  <= pending_n;
            assigned <= assigned_n;
            for (int s = 0; s < NS; s++) owner[s] <= owner_n[s];
            for (int k = 0; k < N_LIFTS; k++) count[k] <= count_n[k];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = sel_found  ? ST_SCORE : ST_IDLE;
            ST_SCORE: next_state = cost_found ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: next_state = hs         ? ST_IDLE  : ST_ISSUE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Capture the selected call and lift, advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= '0;
            cur_slot <= '0;
            cur_lift <= '0;
        end else begin
            if ((state == ST_IDLE) && sel_found) cur_slot <= sel_slot;
            if ((state == ST_SCORE) && cost_found) cur_lift <= cost_lift;
            if (((state == ST_SCORE) && !cost_found) || hs) rr <= slot_inc;
        end
    end

    // FSM output logic: next values of the offer lanes
    always_comb begin
        valid_n = '0;
        up_n    = '0;
        floor_n = '0;
        for (int k = 0; k < N_LIFTS; k++) begin
            if ((next_state == ST_ISSUE) && (issue_lift == LW'(k))) begin
                valid_n[k]          = 1'b1;
                up_n[k]             = call_up;
                floor_n[k*FW +: FW] = call_floor;
            end else begin
                valid_n[k]          = 1'b0;
                up_n[k]             = 1'b0;
                floor_n[k*FW +: FW] = '0;
            end
        end
    end

    // Registered offer and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            up_r    <= '0;
            floor_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= valid_n;
            up_r    <= up_n;
            floor_r <= floor_n;
            busy_r  <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench for elevator_dispatcher: directed calls push expected
// offers; a negedge monitor pops and compares on every accepted offer.
module tb_elevator_dispatcher;

    localparam int NF = 11;
    localparam int NL = 4;
    localparam int FW = 4;

    typedef struct {
        int lift;
        int floor;
        bit up;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NF-1:0]     hall_up_req = '0;
    logic [NF-1:0]     hall_dn_req = '0;
    logic [NL*FW-1:0]  lift_floor = '0;
    logic [NL*2-1:0]   lift_dir = '0;
    logic [NL-1:0]     lift_arrive = '0;
    logic [NL-1:0]     assign_valid;
    logic [NL*FW-1:0]  assign_floor;
    logic [NL-1:0]     assign_up;
    logic [NL-1:0]     assign_ready;
    logic [NF-1:0]     hall_up_lamp;
    logic [NF-1:0]     hall_dn_lamp;
    logic              busy;
    logic [NL-1:0]     ready_mask = '0;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    assign assign_ready = assign_valid & ready_mask;

    elevator_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL), .MAX_PEND(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_up_req  (hall_up_req),
        .hall_dn_req  (hall_dn_req),
        .lift_floor   (lift_floor),
        .lift_dir     (lift_dir),
        .lift_arrive  (lift_arrive),
        .assign_valid (assign_valid),
        .assign_floor (assign_floor),
        .assign_up    (assign_up),
        .assign_ready (assign_ready),
        .hall_up_lamp (hall_up_lamp),
        .hall_dn_lamp (hall_dn_lamp),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lift(input int k, input int fl, input logic [1:0] d);
        lift_floor[k*FW +: FW] = FW'(fl);
        lift_dir[k*2 +: 2]     = d;
    endtask

    task automatic pulse_call(input bit up, input int f);
        if (up) hall_up_req[f] = 1'b1;
        else    hall_dn_req[f] = 1'b1;
        tick();
        hall_up_req = '0;
        hall_dn_req = '0;
    endtask

    task automatic arrive(input int k, input int fl);
        lift_floor[k*FW +: FW] = FW'(fl);
        lift_arrive[k] = 1'b1;
        tick();
        lift_arrive = '0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 60)) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic dispatch(input bit up, input int f, input int k, input string name);
        exp_t e;
        e.lift = k;
        e.floor = f;
        e.up = up;
        exp_q.push_back(e);
        pulse_call(up, f);
        wait_empty(name);
    endtask

    // Monitor: compare every accepted offer against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        logic [NL*FW-1:0] exp_floor;
        if (!rst && ((assign_valid & assign_ready) != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_offer actual valid=%b expected none", assign_valid);
            end else begin
                e = exp_q.pop_front();
                exp_floor = '0;
                exp_floor[e.lift*FW +: FW] = FW'(e.floor);
                check("sb_valid", 32'(assign_valid), 32'(1 << e.lift));
                check("sb_floor", 32'(assign_floor), 32'(exp_floor));
                check("sb_up", 32'(assign_up), e.up ? 32'(1 << e.lift) : 32'd0);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        logic stable;
        int   n;
        exp_t e;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(assign_valid), 32'd0);
        check("rst_floor", 32'(assign_floor), 32'd0);
        check("rst_lamps", 32'({hall_up_lamp, hall_dn_lamp}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // A: idle lifts at 0,5,8,10, up call at 6 -> lift 1 at edge N+2
        set_lift(0, 0, 2'b00); set_lift(1, 5, 2'b00);
        set_lift(2, 8, 2'b00); set_lift(3, 10, 2'b00);
        ready_mask = '0;
        pulse_call(1'b1, 6);
        check("a_n0_valid", 32'(assign_valid), 32'd0);
        tick();
        check("a_n1_valid", 32'(assign_valid), 32'd0);
        tick();
        check("a_n2_valid", 32'(assign_valid), 32'h2);
        check("a_n2_floor", 32'(assign_floor), 32'h0060);
        check("a_n2_up", 32'(assign_up), 32'h2);
        check("a_n2_lamp", 32'(hall_up_lamp), 32'h040);
        check("a_n2_busy", 32'(busy), 32'd1);
        e.lift = 1; e.floor = 6; e.up = 1'b1;
        exp_q.push_back(e);
        ready_mask = '1;
        wait_empty("a_accept");
        arrive(1, 6);
        check("a_lamp_clear", 32'(hall_up_lamp), 32'd0);

        // B: lifts 2,3 saturated, 0,1 moving up -> down call at 5 gets no offer
        set_lift(0, 3, 2'b01); set_lift(1, 7, 2'b01);
        set_lift(2, 0, 2'b00); set_lift(3, 10, 2'b00);
        dispatch(1'b0, 1, 2, "b_d1");
        dispatch(1'b0, 2, 2, "b_d2");
        dispatch(1'b0, 3, 2, "b_d3");
        dispatch(1'b0, 9, 3, "b_d9");
        dispatch(1'b0, 8, 3, "b_d8");
        dispatch(1'b0, 7, 3, "b_d7");
        pulse_call(1'b0, 5);
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | (|assign_valid);
        end
        check("b_no_offer", 32'(seen), 32'd0);
        check("b_dn_lamps", 32'(hall_dn_lamp), 32'h3AE);
        check("b_rr", 32'(dut.rr), 32'd17);
        e.lift = 2; e.floor = 5; e.up = 1'b0;
        exp_q.push_back(e);
        arrive(2, 1);
        wait_empty("b_release");
        check("b_dn_lamps2", 32'(hall_dn_lamp), 32'h3AC);
        arrive(2, 2); arrive(2, 3); arrive(2, 5);
        arrive(3, 9); arrive(3, 8); arrive(3, 7);
        check("b_clean_lamps", 32'(hall_dn_lamp), 32'd0);
        check("b_cnt2", 32'(dut.count[2]), 32'd0);
        check("b_cnt3", 32'(dut.count[3]), 32'd0);

        // C: tie between lifts 0 and 1 at floor 4 -> lift 0
        set_lift(0, 4, 2'b00); set_lift(1, 4, 2'b00);
        set_lift(2, 0, 2'b00); set_lift(3, 10, 2'b00);
        dispatch(1'b1, 4, 0, "c_tie");
        arrive(0, 4);
        check("c_lamp", 32'(hall_up_lamp), 32'd0);
        check("c_cnt0", 32'(dut.count[0]), 32'd0);

        // D: up and down at floor 2 to lift 2, one arrival clears both
        set_lift(0, 10, 2'b00); set_lift(1, 9, 2'b00);
        set_lift(2, 2, 2'b00);  set_lift(3, 8, 2'b00);
        dispatch(1'b1, 2, 2, "d_up");
        dispatch(1'b0, 2, 2, "d_dn");
        check("d_cnt2_two", 32'(dut.count[2]), 32'd2);
        check("d_lamps_on", 32'({hall_up_lamp, hall_dn_lamp}), 32'({11'h004, 11'h004}));
        arrive(2, 2);
        check("d_lamps_off", 32'({hall_up_lamp, hall_dn_lamp}), 32'd0);
        check("d_cnt2_zero", 32'(dut.count[2]), 32'd0);

        // E: arrival clear and new up call on the same slot -> re-dispatched
        set_lift(0, 10, 2'b00); set_lift(1, 3, 2'b00);
        set_lift(2, 9, 2'b00);  set_lift(3, 8, 2'b00);
        dispatch(1'b1, 3, 1, "e_first");
        e.lift = 1; e.floor = 3; e.up = 1'b1;
        exp_q.push_back(e);
        hall_up_req[3] = 1'b1;
        lift_arrive[1] = 1'b1;
        tick();
        hall_up_req = '0;
        lift_arrive = '0;
        check("e_lamp_kept", 32'(hall_up_lamp), 32'h008);
        wait_empty("e_redispatch");
        check("e_cnt1", 32'(dut.count[1]), 32'd1);
        arrive(1, 3);
        check("e_lamp_off", 32'(hall_up_lamp), 32'd0);

        // F: offer held without ready, own arrival during issue, then reset
        set_lift(0, 10, 2'b00); set_lift(1, 0, 2'b00);
        set_lift(2, 8, 2'b00);  set_lift(3, 0, 2'b00);
        dispatch(1'b0, 8, 2, "f_dn8");
        ready_mask = '0;
        pulse_call(1'b1, 7);
        n = 0;
        while ((assign_valid == 4'b0000) && (n < 20)) begin
            tick();
            n++;
        end
        check("f_offer", 32'(assign_valid), 32'h4);
        arrive(2, 8);
        check("f_arr_valid", 32'(assign_valid), 32'h4);
        check("f_arr_lamp", 32'(hall_dn_lamp), 32'd0);
        check("f_arr_cnt", 32'(dut.count[2]), 32'd0);
        stable = 1'b1;
        repeat (20) begin
            tick();
            stable = stable && (assign_valid == 4'b0100)
                     && (assign_floor == 16'h0700) && (assign_up == 4'b0100);
        end
        check("f_stable", 32'(stable), 32'd1);
        rst = 1'b1;
        tick();
        check("f_rst_valid", 32'(assign_valid), 32'd0);
        check("f_rst_floor", 32'(assign_floor), 32'd0);
        check("f_rst_lamps", 32'({hall_up_lamp, hall_dn_lamp}), 32'd0);
        check("f_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("end_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
